// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped, parametrised GPIO port.
// Per-pin direction, synchronised input path, atomic set/clear/toggle of the
// output register, and rising/falling edge interrupts with sticky W1C status
// folded onto a single level interrupt line.
module gpio_ctrl #(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DDIR_RST    = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  inout  wire  [WIDTH-1:0] io_pad,
  input  logic [3:0]       i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_we,
  input  logic             i_re,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  output logic             o_irq
);

  // Word addresses of the register map; 9..15 are unmapped.
  localparam logic [3:0] A_DOUT = 4'd0;
  localparam logic [3:0] A_DDIR = 4'd1;
  localparam logic [3:0] A_DIN  = 4'd2;
  localparam logic [3:0] A_SET  = 4'd3;
  localparam logic [3:0] A_CLR  = 4'd4;
  localparam logic [3:0] A_TOG  = 4'd5;
  localparam logic [3:0] A_RISE = 4'd6;
  localparam logic [3:0] A_FALL = 4'd7;
  localparam logic [3:0] A_IRQ  = 4'd8;

  // Architectural registers.
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] ddir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] irq_stat_q;

  // Input synchroniser chain and edge history.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // Combinational helpers.
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout_nxt;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irq_clr;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_ddir;
  logic             wr_rise;
  logic             wr_fall;

  // Edge events for pins configured as inputs with the matching enable set.
  // Output pins are masked so that driven values reading back through the
  // synchroniser can never raise status.
  function automatic logic [WIDTH-1:0] edge_events(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] prev,
    input logic [WIDTH-1:0] dir,
    input logic [WIDTH-1:0] ren,
    input logic [WIDTH-1:0] fen
  );
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    rise = cur & ~prev & dir & ren;
    fall = ~cur & prev & dir & fen;
    return rise | fall;
  endfunction

  // Pad drivers: DDIR bit 1 releases the pad, 0 drives DOUT onto it.
  for (genvar k = 0; k < WIDTH; k++) begin : g_pad
    assign io_pad[k] = ddir_q[k] ? 1'bz : dout_q[k];
  end

  // Write decode for the plain RW configuration registers.
  always_comb begin
    wr_ddir = i_we && (i_addr == A_DDIR);
    wr_rise = i_we && (i_addr == A_RISE);
    wr_fall = i_we && (i_addr == A_FALL);
  end

  // Next DOUT: full replace or atomic set/clear/toggle; only one address per cycle.
  always_comb begin
    dout_nxt = dout_q;
    if (i_we) begin
      case (i_addr)
        A_DOUT:  dout_nxt = i_wdata;
        A_SET:   dout_nxt = dout_q | i_wdata;
        A_CLR:   dout_nxt = dout_q & ~i_wdata;
        A_TOG:   dout_nxt = dout_q ^ i_wdata;
        default: dout_nxt = dout_q;
      endcase
    end
  end

  // Configuration and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dout_q    <= '0;
      ddir_q    <= DDIR_RST;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else begin
      dout_q <= dout_nxt;
      if (wr_ddir) ddir_q    <= i_wdata;
      if (wr_rise) rise_en_q <= i_wdata;
      if (wr_fall) fall_en_q <= i_wdata;
    end
  end

  // Input synchroniser: every pin, including outputs, so driven values read back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= io_pad;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign din = sync_q[SYNC_STAGES-1];

  // W1C mask for the interrupt status register.
  always_comb begin
    irq_clr = '0;
    if (i_we && (i_addr == A_IRQ)) irq_clr = i_wdata;
  end

  assign edge_hit = edge_events(din, prev_q, ddir_q, rise_en_q, fall_en_q);

  // Edge history and sticky status; a new edge wins over a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q     <= '0;
      irq_stat_q <= '0;
    end else begin
      prev_q     <= din;
      irq_stat_q <= (irq_stat_q & ~irq_clr) | edge_hit;
    end
  end

  assign o_irq = |irq_stat_q;

  // Read mux over current register values; strobe-only addresses read 0.
  always_comb begin
    rd_mux = '0;
    case (i_addr)
      A_DOUT:  rd_mux = dout_q;
      A_DDIR:  rd_mux = ddir_q;
      A_DIN:   rd_mux = din;
      A_RISE:  rd_mux = rise_en_q;
      A_FALL:  rd_mux = fall_en_q;
      A_IRQ:   rd_mux = irq_stat_q;
      default: rd_mux = '0;
    endcase
  end

  // Registered read port; data holds between reads, valid pulses one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= i_re;
      if (i_re) o_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Testbench for gpio_ctrl: main 32-bit instance plus an 8-bit, 3-stage instance.
module tb_gpio_ctrl;

  localparam int W  = 32;
  localparam int SS = 2;

  localparam logic [3:0] A_DOUT = 4'd0;
  localparam logic [3:0] A_DDIR = 4'd1;
  localparam logic [3:0] A_DIN  = 4'd2;
  localparam logic [3:0] A_SET  = 4'd3;
  localparam logic [3:0] A_CLR  = 4'd4;
  localparam logic [3:0] A_TOG  = 4'd5;
  localparam logic [3:0] A_RISE = 4'd6;
  localparam logic [3:0] A_FALL = 4'd7;
  localparam logic [3:0] A_IRQ  = 4'd8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [3:0]    addr = 4'd0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          irq;
  wire  [W-1:0]  pad;
  logic [W-1:0]  drv_en = '1;
  logic [W-1:0]  drv_val = '0;

  logic          re8 = 1'b0;
  logic          we8 = 1'b0;
  logic [3:0]    addr8 = 4'd0;
  logic [7:0]    wdata8 = '0;
  logic [7:0]    rdata8;
  logic          rvalid8;
  logic          irq8;
  wire  [7:0]    pad8;
  logic [7:0]    drv8 = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [W-1:0] exp;
  } rd_t;
  rd_t sbq[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < W; k++) begin : g_drv
    assign pad[k] = drv_en[k] ? drv_val[k] : 1'bz;
  end
  assign pad8 = drv8;

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .DDIR_RST({W{1'b1}})) dut (
    .i_clk(clk), .i_rst(rst), .io_pad(pad), .i_addr(addr), .i_wdata(wdata),
    .i_we(we), .i_re(re), .o_rdata(rdata), .o_rvalid(rvalid), .o_irq(irq)
  );

  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(3), .DDIR_RST(8'hFF)) dut8 (
    .i_clk(clk), .i_rst(rst), .io_pad(pad8), .i_addr(addr8), .i_wdata(wdata8),
    .i_we(we8), .i_re(re8), .o_rdata(rdata8), .o_rvalid(rvalid8), .o_irq(irq8)
  );

  task automatic push_exp(input logic [W-1:0] e, input string nm);
    rd_t t;
    t.name = nm;
    t.exp  = e;
    sbq.push_back(t);
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_req(input logic [3:0] a, input logic [W-1:0] e, input string nm);
    @(negedge clk);
    re = 1'b1; addr = a;
    push_exp(e, nm);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d reads still outstanding, want 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  // Scoreboard: rvalid must follow each accepted i_re by one edge, data popped in order.
  task automatic sb_monitor();
    logic mon_re;
    rd_t  e;
    forever begin
      @(posedge clk);
      mon_re = re & ~rst;
      #1;
      if (mon_re) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: read with no expectation queued, rdata=%h", rdata);
        end else begin
          e = sbq.pop_front();
          if (rvalid !== 1'b1 || rdata !== e.exp) begin
            errors++;
            $display("FAIL %s: rvalid=%b rdata=%h, want rvalid=1 rdata=%h", e.name, rvalid, rdata, e.exp);
          end
        end
      end else if (rvalid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_spurious: rvalid=%b, want 0", rvalid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_rd: rvalid=%b rdata=%h, want 0/0", rvalid, rdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: irq=%b, want 0", irq);
    end
    read_req(A_DDIR, 32'hFFFF_FFFF, "reset_ddir");
    read_req(A_DOUT, 32'h0, "reset_dout");
    read_req(A_IRQ,  32'h0, "reset_irqstat");
    read_req(A_RISE, 32'h0, "reset_rise_en");
    drain("reset");
  endtask

  task automatic test_output_ops();
    @(negedge clk);
    drv_en = 32'hFFFF_FF00;
    wr(A_DDIR, 32'hFFFF_FF00);
    wr(A_DOUT, 32'hFFFF_FFA5);
    checks++;
    if (pad !== 32'h0000_00A5) begin errors++; $display("FAIL pad_dout: pad=%h, want %h", pad, 32'h0000_00A5); end
    wr(A_SET, 32'h0A);
    checks++;
    if (pad !== 32'h0000_00AF) begin errors++; $display("FAIL pad_set: pad=%h, want %h", pad, 32'h0000_00AF); end
    wr(A_CLR, 32'h03);
    checks++;
    if (pad !== 32'h0000_00AC) begin errors++; $display("FAIL pad_clr: pad=%h, want %h", pad, 32'h0000_00AC); end
    wr(A_TOG, 32'hFF);
    checks++;
    if (pad !== 32'h0000_0053) begin errors++; $display("FAIL pad_tog: pad=%h, want %h", pad, 32'h0000_0053); end
    wr(4'd9, 32'h1234_5678);
    read_req(A_DOUT, 32'hFFFF_FF53, "dout_readback");
    read_req(A_SET,  32'h0, "set_reads0");
    read_req(A_CLR,  32'h0, "clr_reads0");
    read_req(A_TOG,  32'h0, "tog_reads0");
    read_req(4'd9,   32'h0, "unmapped_reads0");
    read_req(A_DDIR, 32'hFFFF_FF00, "ddir_readback");
    repeat (3) @(negedge clk);
    read_req(A_DIN,  32'h0000_0053, "din_outputs");
    drain("output_ops");
  endtask

  task automatic test_sync_latency();
    wr(A_DDIR, 32'hFFFF_FFFF);
    drv_en = '1;
    drv_val = '0;
    repeat (4) @(negedge clk);
    drv_val[4] = 1'b1;
    for (int k = 1; k <= SS + 3; k++) begin
      re = 1'b1; addr = A_DIN;
      push_exp((k > SS) ? 32'h10 : 32'h0, $sformatf("din_sync_k%0d", k));
      @(negedge clk);
    end
    re = 1'b0;
    drain("sync");
  endtask

  task automatic test_rise_irq();
    drv_val[4] = 1'b0;
    repeat (SS + 3) @(negedge clk);
    wr(A_RISE, 32'h10);
    read_req(A_IRQ, 32'h0, "irq_before_rise");
    drv_val[4] = 1'b1;
    for (int k = 1; k <= SS + 2; k++) begin
      @(negedge clk);
      checks++;
      if (irq !== (k >= SS + 1)) begin
        errors++;
        $display("FAIL rise_irq_k%0d: irq=%b, want %b", k, irq, (k >= SS + 1));
      end
    end
    read_req(A_IRQ, 32'h10, "irqstat_rise");
    drv_val[4] = 1'b0;
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL fall_no_change: irq=%b, want 1", irq); end
    read_req(A_IRQ, 32'h10, "irqstat_after_fall");
    wr(A_IRQ, 32'h01);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL w1c_other_bit: irq=%b, want 1", irq); end
    wr(A_IRQ, 32'h10);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clear: irq=%b, want 0", irq); end
    read_req(A_IRQ, 32'h0, "irqstat_cleared");
    drain("rise");
  endtask

  task automatic test_set_wins();
    wr(A_RISE, 32'h0);
    wr(A_FALL, 32'h1);
    drv_val[0] = 1'b1;
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rise_disabled: irq=%b, want 0", irq); end
    drv_val[0] = 1'b0;
    repeat (SS) @(negedge clk);
    we = 1'b1; addr = A_IRQ; wdata = 32'h1;
    @(negedge clk);
    we = 1'b0;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL set_wins: irq=%b, want 1", irq); end
    read_req(A_IRQ, 32'h1, "irqstat_set_wins");
    wr(A_IRQ, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL set_wins_clear: irq=%b, want 0", irq); end
    drain("set_wins");
  endtask

  task automatic test_output_mask();
    wr(A_IRQ, 32'hFFFF_FFFF);
    wr(A_FALL, 32'h10);
    wr(A_RISE, 32'h10);
    @(negedge clk);
    drv_en[4] = 1'b0;
    wr(A_DDIR, 32'hFFFF_FFEF);
    checks++;
    if (pad[4] !== 1'b1) begin errors++; $display("FAIL mask_pad_hi: pad4=%b, want 1", pad[4]); end
    wr(A_TOG, 32'h10);
    checks++;
    if (pad[4] !== 1'b0) begin errors++; $display("FAIL mask_pad_lo: pad4=%b, want 0", pad[4]); end
    repeat (SS + 3) @(negedge clk);
    wr(A_TOG, 32'h10);
    repeat (SS + 3) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq: irq=%b, want 0", irq); end
    read_req(A_IRQ,  32'h0, "mask_irqstat");
    read_req(A_DIN,  32'h10, "mask_din_readback");
    read_req(A_DOUT, 32'hFFFF_FF53, "mask_dout");
    read_req(A_FALL, 32'h10, "fall_en_readback");
    drain("mask");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    re = 1'b1; we = 1'b1; addr = A_RISE; wdata = 32'hAB;
    push_exp(32'h10, "rw_same_old");
    @(negedge clk);
    we = 1'b0;
    push_exp(32'hAB, "rw_same_new");
    @(negedge clk);
    addr = A_FALL;
    push_exp(32'h10, "b2b_fall");
    @(negedge clk);
    addr = A_DDIR;
    push_exp(32'hFFFF_FFEF, "b2b_ddir");
    @(negedge clk);
    re = 1'b0;
    drain("b2b");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    rst = 1'b1; we = 1'b1; re = 1'b1; addr = A_DOUT; wdata = 32'h1234;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    drv_en = '1;
    drv_val = '0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || rdata !== '0) begin
      errors++;
      $display("FAIL abort_rd: rvalid=%b rdata=%h, want 0/0", rvalid, rdata);
    end
    read_req(A_DOUT, 32'h0, "abort_dout");
    read_req(A_RISE, 32'h0, "abort_rise_en");
    read_req(A_FALL, 32'h0, "abort_fall_en");
    read_req(A_DDIR, 32'hFFFF_FFFF, "abort_ddir");
    drain("abort");
  endtask

  task automatic test_param();
    @(negedge clk);
    re8 = 1'b1; addr8 = A_DDIR;
    @(posedge clk);
    #1;
    checks++;
    if (rvalid8 !== 1'b1 || rdata8 !== 8'hFF) begin
      errors++;
      $display("FAIL p8_ddir: rvalid=%b rdata=%h, want 1/ff", rvalid8, rdata8);
    end
    @(negedge clk);
    re8 = 1'b0;
    drv8 = 8'h00;
    repeat (6) @(negedge clk);
    drv8[4] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      re8 = 1'b1; addr8 = A_DIN;
      @(posedge clk);
      #1;
      checks++;
      if (rvalid8 !== 1'b1 || rdata8 !== ((k > 3) ? 8'h10 : 8'h00)) begin
        errors++;
        $display("FAIL p8_sync_k%0d: rvalid=%b rdata=%h, want 1/%h", k, rvalid8, rdata8, (k > 3) ? 8'h10 : 8'h00);
      end
      @(negedge clk);
    end
    re8 = 1'b0;
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_output_ops();
    test_sync_latency();
    test_rise_irq();
    test_set_wins();
    test_output_mask();
    test_back_to_back();
    test_reset_abort();
    test_param();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
